axis_stereo_bridge: RTL
=======================

// Module: axis_stereo_bridge
// PURPOSE
//  Sits between the Pmod I2S2 AXIS controller and the ANC DSP datapath.
//  RX: unpacks 2-beat AXIS packets (left, then right+last) into a sign-extended stereo sample pair with a 1-cycle strobe.
//  TX: saturates DSP-width stereo results to SAMPLE_W and emits them as a 2-beat packet for the controller.
//  Also provides sticky framing/overrun/saturation flags and a link-loss monitor.
// PARAMETERS
//  SAMPLE_W      24    audio word width on the AXIS side (bits [SAMPLE_W-1:0] of each 32-bit beat)
//  DSP_W         32    signed sample width on the DSP side (DSP_W >= SAMPLE_W)
//  LOSS_TIMEOUT  1024  cycles without a completed RX packet before link_lost asserts
// PORTS
//  axis_clk       in   1      system clock (~22.591 MHz)
//  axis_resetn    in   1      synchronous reset, active low
//  s_axis_data    in   32     RX beat from I2S controller
//  s_axis_valid   in   1      RX beat valid
//  s_axis_ready   out  1      RX beat accept
//  s_axis_last    in   1      RX beat is right channel / end of packet
//  smp_l          out  DSP_W  received left sample, sign-extended
//  smp_r          out  DSP_W  received right sample, sign-extended
//  smp_valid      out  1      1-cycle strobe: smp_l/smp_r updated
//  dsp_l          in   DSP_W  left sample to transmit, signed
//  dsp_r          in   DSP_W  right sample to transmit, signed
//  dsp_valid      in   1      dsp_l/dsp_r valid
//  dsp_ready      out  1      bridge can accept a TX pair
//  m_axis_data    out  32     TX beat to I2S controller
//  m_axis_valid   out  1      TX beat valid
//  m_axis_ready   in   1      TX beat accept
//  m_axis_last    out  1      TX beat is right channel
//  clear_status   in   1      clears all sticky flags
//  frame_err      out  1      sticky: malformed RX packet seen
//  tx_overrun     out  1      sticky: dsp_valid dropped while busy
//  sat_flag       out  1      sticky: a TX sample was clipped
//  link_lost      out  1      no RX packet for LOSS_TIMEOUT cycles
// BEHAVIOUR
//  Reset (axis_resetn=0 at a clock edge):
//   - All outputs 0; RX FSM returns to RX_L, TX FSM to TX_IDLE.
//   - Partial packets discarded; sample registers and timeout counter cleared.
//  RX FSM {RX_L, RX_R, RX_DRAIN}; s_axis_ready=1 in every state from the first cycle after reset (no backpressure).
//   - RX_L, beat with last=0: capture left = data[SAMPLE_W-1:0]; -> RX_R.
//   - RX_L, beat with last=1: set frame_err, discard; stay in RX_L.
//   - RX_R, beat with last=1: capture right; next cycle smp_valid=1 with both samples sign-extended to DSP_W; -> RX_L.
//   - RX_R, beat with last=0: set frame_err; -> RX_DRAIN.
//   - RX_DRAIN: discard beats until a last=1 beat is accepted; -> RX_L. No smp_valid is produced.
//   - smp_l/smp_r hold their value between strobes.
//  TX FSM {TX_IDLE, TX_L, TX_R}.
//   - dsp_ready=1 only in TX_IDLE.
//   - dsp_valid & dsp_ready: register saturated pair; -> TX_L.
//   - TX_L: m_axis_valid=1, last=0, data={zeros, sat_l}; on handshake -> TX_R.
//   - TX_R: m_axis_valid=1, last=1, data={zeros, sat_r}; on handshake -> TX_IDLE.
//   - m_axis_data/m_axis_last are stable while valid & !ready; bits [31:SAMPLE_W] are always 0.
//   - dsp_valid when not in TX_IDLE: pair dropped, tx_overrun set.
//  Saturation: x > 2^(SAMPLE_W-1)-1 -> 0x7FFFFF; x < -2^(SAMPLE_W-1) -> 0x800000 (SAMPLE_W=24); else x[SAMPLE_W-1:0]. Any clip sets sat_flag.
//  Link monitor: counter increments each cycle and saturates at LOSS_TIMEOUT; link_lost = (count == LOSS_TIMEOUT); a smp_valid cycle resets count to 0.
//  Sticky flags: clear_status clears them next cycle; a set event in the same cycle wins (flag stays 1).
//  RX and TX paths are fully independent; simultaneous activity on both is legal.
// STRUCTURE
//  Package anc_audio_pkg:
//   - AXIS_W=32, SAMPLE_W default
//   - rx_state_t, tx_state_t enums
//   - sat_max/sat_min constants
//  Sub-module sat_clip (signed DSP_W -> SAMPLE_W saturator with clip flag), instantiated once per channel.
// TESTING
//  1. Packet 0x00FFFFFE / 0x00000003(last) -> smp_valid 1 cycle after the 2nd beat; smp_l=0xFFFFFFFE, smp_r=0x00000003.
//  2. Lone last=1 beat, then a good packet -> frame_err=1; the good packet still strobes. Beats L, L, L(last) -> frame_err, no strobe, next packet OK.
//  3. dsp_l=0x00900000, dsp_r=-0x00900000, m_axis_ready=1 -> beats 0x007FFFFF(last=0), 0x00800000(last=1); sat_flag=1.
//  4. m_axis_ready=0 for 10 cycles during TX_L, second dsp_valid -> beat held stable, tx_overrun=1, dsp_ready=0 until TX_R completes.
//  5. No RX for LOSS_TIMEOUT cycles -> link_lost=1 exactly at cycle 1024; clears on next strobe. clear_status and set event in the same cycle -> flag stays 1.
//  6. Reset asserted in RX_R and in TX_R -> all outputs 0 the next cycle; a fresh packet afterwards behaves as in test 1.

Source files
------------

// File: rtl/anc_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : anc_audio_pkg
//  Description : Shared widths, FSM state types and saturation constants for
//                the Pmod I2S2 <-> ANC DSP stereo bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package anc_audio_pkg;

   localparam int AXIS_W       = 32;
   localparam int DEF_SAMPLE_W = 24;

   typedef enum logic [1:0] {
      RX_L     = 2'd0,
      RX_R     = 2'd1,
      RX_DRAIN = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_L    = 2'd1,
      TX_R    = 2'd2
   } tx_state_t;

   // Clip limits for the default audio word width
   localparam logic [DEF_SAMPLE_W-1:0] c_sat_max = {1'b0, {(DEF_SAMPLE_W-1){1'b1}}};
   localparam logic [DEF_SAMPLE_W-1:0] c_sat_min = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/axis_stereo_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_stereo_bridge_if
//  Description : One AXI-Stream audio beat channel (data/valid/ready/last).
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_stereo_bridge_if;
   import anc_audio_pkg::*;

   logic [AXIS_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;

   modport master (output data, output valid, output last, input  ready);
   modport slave  (input  data, input  valid, input  last, output ready);

endinterface
`default_nettype wire

// File: rtl/axis_stereo_bridge_sat.sv
`default_nettype none
// ============================================================================
//  Module      : sat_clip
//  Description : Signed DSP_W -> SAMPLE_W saturator with a clip indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_clip #(
   parameter int DSP_W    = 32,
   parameter int SAMPLE_W = 24
) (
   input  wire logic signed [DSP_W-1:0] i_din,
   output logic [SAMPLE_W-1:0]          o_dout,
   output logic                         o_clip
);

   localparam logic [SAMPLE_W-1:0] c_max = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] c_min = {1'b1, {(SAMPLE_W-1){1'b0}}};

   // The value fits when every bit from the target sign bit upward agrees
   logic [DSP_W-SAMPLE_W:0] w_hi;
   logic                    w_pos_ovf;
   logic                    w_neg_ovf;

   assign w_hi      = i_din[DSP_W-1:SAMPLE_W-1];
   assign w_pos_ovf = ~i_din[DSP_W-1] & (|w_hi);
   assign w_neg_ovf =  i_din[DSP_W-1] & ~(&w_hi);

   // Select pass-through or the clip limit on the overflowing side
   always_comb begin
      o_dout = i_din[SAMPLE_W-1:0];
      o_clip = 1'b0;
      if (w_pos_ovf) begin
         o_dout = c_max;
         o_clip = 1'b1;
      end else if (w_neg_ovf) begin
         o_dout = c_min;
         o_clip = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_stereo_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axis_stereo_bridge
//  Description : Unpacks 2-beat RX AXIS packets into stereo sample pairs and
//                packs saturated DSP stereo results into 2-beat TX packets.
//                Sticky framing/overrun/saturation flags, link-loss monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_stereo_bridge
   import anc_audio_pkg::*;
#(
   parameter int SAMPLE_W     = DEF_SAMPLE_W,
   parameter int DSP_W        = 32,
   parameter int LOSS_TIMEOUT = 1024
) (
   input  wire logic                    axis_clk,
   input  wire logic                    axis_resetn,
   axis_stereo_bridge_if.slave          s_axis,
   output logic signed [DSP_W-1:0]      smp_l,
   output logic signed [DSP_W-1:0]      smp_r,
   output logic                         smp_valid,
   input  wire logic signed [DSP_W-1:0] dsp_l,
   input  wire logic signed [DSP_W-1:0] dsp_r,
   input  wire logic                    dsp_valid,
   output logic                         dsp_ready,
   axis_stereo_bridge_if.master         m_axis,
   input  wire logic                    clear_status,
   output logic                         frame_err,
   output logic                         tx_overrun,
   output logic                         sat_flag,
   output logic                         link_lost
);

   localparam int                c_cnt_w    = $clog2(LOSS_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_loss_max = c_cnt_w'(LOSS_TIMEOUT);

   logic                    r_run;
   rx_state_t               r_rx_state, w_rx_next;
   tx_state_t               r_tx_state, w_tx_next;
   logic                    w_rx_beat, w_rx_cap_l, w_rx_cap_r, w_rx_ferr;
   logic                    w_tx_load, w_tx_ovr, w_clip_l, w_clip_r;
   logic [SAMPLE_W-1:0]     r_left, r_tx_l, r_tx_r, w_sat_l, w_sat_r;
   logic signed [DSP_W-1:0] r_smp_l, r_smp_r;
   logic                    r_smp_valid, r_frame_err, r_tx_overrun, r_sat_flag;
   logic [c_cnt_w-1:0]      r_loss_cnt;
   logic [AXIS_W-1:0]       w_m_data;

   // Audio bits above SAMPLE_W carry nothing for us
   generate
      if (SAMPLE_W < AXIS_W) begin : g_pad
         logic w_unused_pad;
         assign w_unused_pad = ^s_axis.data[AXIS_W-1:SAMPLE_W];
      end
   endgenerate

   // Handshakes open one cycle after reset so every output reads 0 in reset
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn) r_run <= 1'b0;
      else              r_run <= 1'b1;
   end

   assign s_axis.ready = r_run;
   assign w_rx_beat    = s_axis.valid & r_run;

   // RX state register
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn) r_rx_state <= RX_L;
      else              r_rx_state <= w_rx_next;
   end

   // RX packet parser: left, then right+last; anything else is a framing error
   always_comb begin
      w_rx_next  = r_rx_state;
      w_rx_cap_l = 1'b0;
      w_rx_cap_r = 1'b0;
      w_rx_ferr  = 1'b0;
      if (w_rx_beat) begin
         case (r_rx_state)
            RX_L: begin
               if (s_axis.last) w_rx_ferr = 1'b1;
               else begin
                  w_rx_cap_l = 1'b1;
                  w_rx_next  = RX_R;
               end
            end
            RX_R: begin
               if (s_axis.last) begin
                  w_rx_cap_r = 1'b1;
                  w_rx_next  = RX_L;
               end else begin
                  w_rx_ferr  = 1'b1;
                  w_rx_next  = RX_DRAIN;
               end
            end
            default: begin
               if (s_axis.last) w_rx_next = RX_L;
            end
         endcase
      end
   end

   // Sample registers: publish the sign-extended pair with a one-cycle strobe
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn) begin
         r_left      <= '0;
         r_smp_l     <= '0;
         r_smp_r     <= '0;
         r_smp_valid <= 1'b0;
      end else begin
         r_smp_valid <= w_rx_cap_r;
         if (w_rx_cap_l) r_left <= s_axis.data[SAMPLE_W-1:0];
         if (w_rx_cap_r) begin
            r_smp_l <= DSP_W'($signed(r_left));
            r_smp_r <= DSP_W'($signed(s_axis.data[SAMPLE_W-1:0]));
         end
      end
   end

   sat_clip #(.DSP_W(DSP_W), .SAMPLE_W(SAMPLE_W)) u_sat_l (
      .i_din (dsp_l), .o_dout(w_sat_l), .o_clip(w_clip_l)
   );
   sat_clip #(.DSP_W(DSP_W), .SAMPLE_W(SAMPLE_W)) u_sat_r (
      .i_din (dsp_r), .o_dout(w_sat_r), .o_clip(w_clip_r)
   );

   // TX state register
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn) r_tx_state <= TX_IDLE;
      else              r_tx_state <= w_tx_next;
   end

   // TX sequencer: accept a pair when idle, then emit left and right beats
   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_load = 1'b0;
      w_tx_ovr  = 1'b0;
      dsp_ready = 1'b0;
      w_m_data  = '0;
      m_axis.valid = 1'b0;
      m_axis.last  = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            dsp_ready = r_run;
            if (dsp_valid & r_run) begin
               w_tx_load = 1'b1;
               w_tx_next = TX_L;
            end
         end
         TX_L: begin
            w_tx_ovr     = dsp_valid;
            m_axis.valid = 1'b1;
            w_m_data[SAMPLE_W-1:0] = r_tx_l;
            if (m_axis.ready) w_tx_next = TX_R;
         end
         default: begin
            w_tx_ovr     = dsp_valid;
            m_axis.valid = 1'b1;
            m_axis.last  = 1'b1;
            w_m_data[SAMPLE_W-1:0] = r_tx_r;
            if (m_axis.ready) w_tx_next = TX_IDLE;
         end
      endcase
   end

   assign m_axis.data = w_m_data;

   // Hold the saturated pair for the duration of the packet
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn) begin
         r_tx_l <= '0;
         r_tx_r <= '0;
      end else if (w_tx_load) begin
         r_tx_l <= w_sat_l;
         r_tx_r <= w_sat_r;
      end
   end

   // Sticky flags: a set event in the clearing cycle keeps the flag high
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn) begin
         r_frame_err  <= 1'b0;
         r_tx_overrun <= 1'b0;
         r_sat_flag   <= 1'b0;
      end else begin
         r_frame_err  <= w_rx_ferr | (r_frame_err  & ~clear_status);
         r_tx_overrun <= w_tx_ovr  | (r_tx_overrun & ~clear_status);
         r_sat_flag   <= (w_tx_load & (w_clip_l | w_clip_r)) |
                         (r_sat_flag & ~clear_status);
      end
   end

   // Link monitor: saturating count of cycles since the last sample strobe
   always_ff @(posedge axis_clk) begin
      if (!axis_resetn)             r_loss_cnt <= '0;
      else if (r_smp_valid)         r_loss_cnt <= '0;
      else if (r_loss_cnt != c_loss_max) r_loss_cnt <= r_loss_cnt + 1'b1;
   end

   assign smp_l      = r_smp_l;
   assign smp_r      = r_smp_r;
   assign smp_valid  = r_smp_valid;
   assign frame_err  = r_frame_err;
   assign tx_overrun = r_tx_overrun;
   assign sat_flag   = r_sat_flag;
   assign link_lost  = (r_loss_cnt == c_loss_max);

endmodule
`default_nettype wire
